gpio_input_conditioner: RTL and testbench



---
 rtl/gpio_cond_pkg.sv | 18 +
 rtl/gpio_debounce_bit.sv | 80 ++++++++
 rtl/gpio_input_conditioner.sv | 75 +++++++
 tb/tb_gpio_input_conditioner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// rtl/gpio_cond_pkg.sv - width helpers and per-bit event record for the GPIO input conditioner
package gpio_cond_pkg;

  function automatic int DB_CNT_W(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

  function automatic int TICK_W(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } gpio_bit_evt_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one-bit 2-FF synchronizer, tick-based debounce and edge flags
// Edge flags exist only when GPIO_COND_EDGE_EN is defined.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int   DEBOUNCE_TICKS = 10,
  parameter logic RESET_VAL      = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          raw_i,
  input  logic          tick_i,
  input  logic          evt_clr_i,
  output gpio_bit_evt_t evt_o
);

  localparam int            CW       = DB_CNT_W(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized pin agrees with the accepted level restarts the window.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= RESET_VAL;
      s2_q    <= RESET_VAL;
      level_q <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GPIO_COND_EDGE_EN
  logic accept;
  logic rise_q, fall_q;

  assign accept = (s2_q != level_q) && tick_i && (cnt_q == CNT_LAST);

  // A new edge beats a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      if (accept && s2_q)       rise_q <= 1'b1;
      else if (evt_clr_i)       rise_q <= 1'b0;
      if (accept && !s2_q)      fall_q <= 1'b1;
      else if (evt_clr_i)       fall_q <= 1'b0;
    end
  end

  assign evt_o = '{level: level_q, rise: rise_q, fall: fall_q};
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr_i;
  assign evt_o = '{level: level_q, rise: 1'b0, fall: 1'b0};
`endif

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - shared debounce tick, per-bit conditioners and change interrupt
// Edge flags and change_irq are built only when GPIO_COND_EDGE_EN is defined.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int              clk_mhz        = 50,
  parameter int              W_IN           = 21,
  parameter int              TICK_CYCLES    = clk_mhz * 1000,
  parameter int              DEBOUNCE_TICKS = 10,
  parameter logic [W_IN-1:0] RESET_VAL      = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [W_IN-1:0] raw_in,
  output logic [W_IN-1:0] gpio_in,
  output logic [W_IN-1:0] rise_evt,
  output logic [W_IN-1:0] fall_evt,
  input  logic [W_IN-1:0] evt_clr,
  output logic            change_irq
);

  localparam int            TW        = TICK_W(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q;
  logic          tick_wrap;

  assign tick_wrap  = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);

  // tick_q is high for the one cycle in which the count sits at zero after a wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_wrap;
    end
  end

  gpio_bit_evt_t bit_evt [W_IN];

  for (genvar i = 0; i < W_IN; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_VAL     (RESET_VAL[i])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw_i    (raw_in[i]),
      .tick_i   (tick_q),
      .evt_clr_i(evt_clr[i]),
      .evt_o    (bit_evt[i])
    );
    assign gpio_in[i]  = bit_evt[i].level;
    assign rise_evt[i] = bit_evt[i].rise;
    assign fall_evt[i] = bit_evt[i].fall;
  end

`ifdef GPIO_COND_EDGE_EN
  logic change_irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) change_irq_q <= 1'b0;
    else          change_irq_q <= |(rise_evt | fall_evt);
  end

  assign change_irq = change_irq_q;
`else
  assign change_irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - self-checking bench for gpio_input_conditioner (GPIO_COND_EDGE_EN aware)
module tb_gpio_input_conditioner;

`ifdef GPIO_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam logic [3:0] RST_V = 4'b0001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] evt_clr;
  logic [3:0] gpio_in;
  logic [3:0] rise_evt;
  logic [3:0] fall_evt;
  logic       change_irq;

  always #5 clk = ~clk;

  gpio_input_conditioner #(
    .clk_mhz       (50),
    .W_IN          (4),
    .TICK_CYCLES   (4),
    .DEBOUNCE_TICKS(3),
    .RESET_VAL     (RST_V)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .gpio_in   (gpio_in),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt),
    .evt_clr   (evt_clr),
    .change_irq(change_irq)
  );

  typedef struct {
    string      name;
    logic [3:0] gpio;
    logic [3:0] rise;
    logic [3:0] fall;
    int         lat_min;
    int         lat_max;
  } exp_t;

  typedef struct {
    int         b;
    logic       v;
    logic [3:0] gpio;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [3:0] ev(input logic [3:0] m);
    return EDGE_EN ? m : 4'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d clk, expected %0d..%0d clk", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input string name, input logic [3:0] g, input logic [3:0] r,
                             input logic [3:0] f);
    exp_t e;
    e.name = name; e.gpio = g; e.rise = r; e.fall = f; e.lat_min = 11; e.lat_max = 14;
    sb.push_back(e);
  endtask

  // Waits (bounded) for gpio_in to move, then checks it against the oldest expectation.
  task automatic await_change(input bit drop_clr);
    exp_t       e;
    logic [3:0] prev;
    int         n;
    bit         seen;
    e    = sb.pop_front();
    prev = gpio_in;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 24) begin
      @(posedge clk);
      #1;
      n++;
      if (gpio_in !== prev) seen = 1'b1;
    end
    if (drop_clr) evt_clr = 4'h0;
    chk_rng({e.name, "_latency"}, n, e.lat_min, e.lat_max);
    chk({e.name, "_gpio"}, gpio_in, e.gpio);
    chk({e.name, "_rise"}, rise_evt, e.rise);
    chk({e.name, "_fall"}, fall_evt, e.fall);
  endtask

  task automatic clear_all();
    evt_clr = 4'hF;
    step(1);
    evt_clr = 4'h0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] obs;

    vecs[0] = '{2, 1'b1, 4'b0101, ev(4'b0100), 4'h0};
    vecs[1] = '{0, 1'b0, 4'b0100, 4'h0, ev(4'b0001)};
    vecs[2] = '{3, 1'b1, 4'b1100, ev(4'b1000), 4'h0};
    vecs[3] = '{0, 1'b1, 4'b1101, ev(4'b0001), 4'h0};

    // Reset held with all pins high.
    reset_n = 1'b0;
    raw_in  = 4'hF;
    evt_clr = 4'h0;
    step(3);
    chk("reset_gpio", gpio_in, RST_V);
    chk("reset_rise", rise_evt, 4'h0);
    chk("reset_fall", fall_evt, 4'h0);
    chk("reset_irq", change_irq, 1'b0);

    reset_n = 1'b1;
    obs = RST_V;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (gpio_in !== RST_V) obs = gpio_in;
    end
    chk("reset_hold_8clk", obs, RST_V);
    raw_in = RST_V;
    step(20);
    chk("idle_gpio", gpio_in, RST_V);

    // Clean steps from the vector table.
    for (int i = 0; i < 4; i++) begin
      raw_in[vecs[i].b] = vecs[i].v;
      expect_step($sformatf("vec%0d", i), vecs[i].gpio, vecs[i].rise, vecs[i].fall);
      await_change(1'b0);
      chk($sformatf("vec%0d_irq_lag", i), change_irq, 1'b0);
      step(1);
      chk($sformatf("vec%0d_irq", i), change_irq, EDGE_EN);
      clear_all();
    end

    // Bounce on bit 1: toggle every 3 clk for 30 clk, then settle high.
    obs = gpio_in;
    for (int i = 0; i < 10; i++) begin
      raw_in[1] = ~raw_in[1];
      for (int k = 0; k < 3; k++) begin
        step(1);
        if (gpio_in !== 4'b1101) obs = gpio_in;
      end
    end
    chk("bounce_hold", obs, 4'b1101);
    raw_in[1] = 1'b1;
    expect_step("bounce_settle", 4'b1111, ev(4'b0010), 4'h0);
    await_change(1'b0);
    clear_all();

    // Simultaneous falls on bits 3 and 2.
    raw_in[3:2] = 2'b00;
    expect_step("simul", 4'b0011, 4'h0, ev(4'b1100));
    await_change(1'b0);
    step(1);
    chk("simul_irq", change_irq, EDGE_EN);
    evt_clr = 4'b1000;
    step(1);
    evt_clr = 4'h0;
    chk("simul_clr3_fall", fall_evt, ev(4'b0100));
    chk("simul_clr3_irq", change_irq, EDGE_EN);
    step(1);
    chk("simul_clr3_irq_hold", change_irq, EDGE_EN);
    clear_all();

    // Clear held through the acceptance cycle of a new rise on bit 2.
    evt_clr = 4'b0100;
    raw_in[2] = 1'b1;
    expect_step("collide", 4'b0111, ev(4'b0100), 4'h0);
    await_change(1'b1);
    step(1);
    chk("collide_rise_kept", rise_evt, ev(4'b0100));
    step(1);
    chk("collide_irq", change_irq, EDGE_EN);
    evt_clr = 4'hF;
    step(1);
    evt_clr = 4'h0;
    chk("clrall_rise", rise_evt, 4'h0);
    chk("clrall_fall", fall_evt, 4'h0);
    step(1);
    chk("clrall_irq", change_irq, 1'b0);

    // Reset in the middle of a debounce on bit 0.
    raw_in[0] = 1'b0;
    step(8);
    chk("middb_gpio", gpio_in, 4'b0111);
    reset_n = 1'b0;
    #1;
    chk("middb_reset_gpio", gpio_in, RST_V);
    chk("middb_reset_rise", rise_evt, 4'h0);
    chk("middb_reset_irq", change_irq, 1'b0);
    step(2);
    reset_n = 1'b1;
    expect_step("post_reset", 4'b0110, ev(4'b0110), ev(4'b0001));
    await_change(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
